// File: rtl/accumulator_binary_saturating.sv
// Signed saturating accumulator with a one-entry valid/ready output buffer.
// Each accepted operand is added to or subtracted from the running total.
// A load replaces the total instead. Both results are clipped to
// [i_min_limit, i_max_limit]. Sticky flags record every clip.
module accumulator_binary_saturating #(
    parameter int WORD_WIDTH = 0
) (
    input  logic                  i_clock,
    input  logic                  i_clear,
    input  logic [WORD_WIDTH-1:0] i_max_limit,
    input  logic [WORD_WIDTH-1:0] i_min_limit,
    input  logic                  i_load_valid,
    input  logic [WORD_WIDTH-1:0] i_load_value,
    input  logic                  i_input_valid,
    output logic                  o_input_ready,
    input  logic                  i_add_sub,
    input  logic [WORD_WIDTH-1:0] i_input_value,
    output logic                  o_output_valid,
    input  logic                  i_output_ready,
    output logic [WORD_WIDTH-1:0] o_total_out,
    output logic                  o_over_max,
    output logic                  o_under_min,
    input  logic                  i_clear_flags
);

    logic [WORD_WIDTH-1:0] r_total;
    logic                  r_output_valid;
    logic                  r_over_max;
    logic                  r_under_min;

    logic                  w_input_ready;
    logic                  w_accept;
    logic                  w_update;
    logic [WORD_WIDTH:0]   w_total_ext;
    logic [WORD_WIDTH:0]   w_operand_ext;
    logic [WORD_WIDTH:0]   w_max_ext;
    logic [WORD_WIDTH:0]   w_min_ext;
    logic [WORD_WIDTH:0]   w_result;
    logic                  w_clip_hi;
    logic                  w_clip_lo;
    logic [WORD_WIDTH-1:0] w_clipped;

    // Ready depends only on load and buffer state, never on i_input_valid.
    assign w_input_ready = !i_load_valid && (!r_output_valid || i_output_ready);
    assign w_accept      = i_input_valid && w_input_ready;
    assign w_update      = i_load_valid || w_accept;

    // One extra bit of headroom means the add/sub itself cannot overflow.
    assign w_total_ext   = {r_total[WORD_WIDTH-1], r_total};
    assign w_operand_ext = {i_input_value[WORD_WIDTH-1], i_input_value};
    assign w_max_ext     = {i_max_limit[WORD_WIDTH-1], i_max_limit};
    assign w_min_ext     = {i_min_limit[WORD_WIDTH-1], i_min_limit};

    // Pick the unclipped result: a load value, or the sum or difference.
    always_comb begin
        w_result = w_total_ext + w_operand_ext;
        if (i_load_valid)
            w_result = {i_load_value[WORD_WIDTH-1], i_load_value};
        else if (i_add_sub)
            w_result = w_total_ext - w_operand_ext;
    end

    // A result equal to a limit is not a clip. Only strictly beyond counts.
    assign w_clip_hi = $signed(w_result) > $signed(w_max_ext);
    assign w_clip_lo = $signed(w_result) < $signed(w_min_ext);

    // Clip to the limits, then drop the headroom bit.
    always_comb begin
        w_clipped = w_result[WORD_WIDTH-1:0];
        if (w_clip_hi)
            w_clipped = i_max_limit;
        else if (w_clip_lo)
            w_clipped = i_min_limit;
    end

    // Total register and output buffer. A load overwrites any pending result.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_total        <= '0;
            r_output_valid <= 1'b0;
        end else if (w_update) begin
            r_total        <= w_clipped;
            r_output_valid <= 1'b1;
        end else if (i_output_ready) begin
            r_output_valid <= 1'b0;
        end
    end

    // Sticky clip flags. A new clip beats i_clear_flags in the same cycle.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_over_max  <= 1'b0;
            r_under_min <= 1'b0;
        end else begin
            if (w_update && w_clip_hi)
                r_over_max <= 1'b1;
            else if (i_clear_flags)
                r_over_max <= 1'b0;
            if (w_update && w_clip_lo)
                r_under_min <= 1'b1;
            else if (i_clear_flags)
                r_under_min <= 1'b0;
        end
    end

    assign o_input_ready  = w_input_ready;
    assign o_output_valid = r_output_valid;
    assign o_total_out    = r_total;
    assign o_over_max     = r_over_max;
    assign o_under_min    = r_under_min;

endmodule

// File: tb/tb_accumulator_binary_saturating.sv
// Bench for accumulator_binary_saturating at WORD_WIDTH=8.
// A table of hand-computed vectors is applied first. Expected results are queued
// on acceptance and popped when the result appears. Hand-written sequences follow
// for the stall case and for a clear during a stall.
module tb_accumulator_binary_saturating;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clr;
    logic [W-1:0] maxl, minl, ldv, ival, tot;
    logic         ld, iv, irdy, as_, ov, ordy, om, um, clrf;

    accumulator_binary_saturating #(.WORD_WIDTH(W)) dut (
        .i_clock(clk), .i_clear(clr), .i_max_limit(maxl), .i_min_limit(minl),
        .i_load_valid(ld), .i_load_value(ldv), .i_input_valid(iv),
        .o_input_ready(irdy), .i_add_sub(as_), .i_input_value(ival),
        .o_output_valid(ov), .i_output_ready(ordy), .o_total_out(tot),
        .o_over_max(om), .o_under_min(um), .i_clear_flags(clrf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ld;
        logic [W-1:0] ldv;
        logic         iv;
        logic         as_;
        logic [W-1:0] val;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        logic         clrf;
        logic         exp_rdy;
        logic [W-1:0] exp_tot;
        logic         exp_om;
        logic         exp_um;
    } vec_t;

    typedef struct {
        logic [W-1:0] tot;
        logic         om;
        logic         um;
    } res_t;

    vec_t vecs[$];
    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Watchdog: stop a run that never finishes.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        res_t r;
        logic pushed;
        clr = 1'b1; maxl = 8'd100; minl = 8'h9C; ld = 0; ldv = 0; iv = 0;
        as_ = 0; ival = 0; ordy = 1; clrf = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset total", tot, 0);
        chk("reset valid", ov, 0);
        chk("reset over", om, 0);
        chk("reset under", um, 0);

        //                 ld ldv    iv as val    mx     mn     clrf rdy tot    om um
        vecs.push_back('{0, 8'h00, 1, 0, 8'd5,  8'd100, 8'h9C, 0, 1, 8'd5,   0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'd7,  8'd100, 8'h9C, 0, 1, 8'd12,  0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'hFD, 8'd100, 8'h9C, 0, 1, 8'd9,   0, 0});
        vecs.push_back('{1, 8'd95, 0, 0, 8'h00, 8'd100, 8'h9C, 0, 0, 8'd95,  0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'd10, 8'd100, 8'h9C, 0, 1, 8'd100, 1, 0});
        vecs.push_back('{0, 8'h00, 1, 1, 8'hFA, 8'd100, 8'h9C, 0, 1, 8'd100, 1, 0});
        vecs.push_back('{1, 8'h80, 0, 0, 8'h00, 8'h7F,  8'h80, 0, 0, 8'h80,  1, 0});
        vecs.push_back('{0, 8'h00, 1, 1, 8'd1,  8'h7F,  8'h80, 0, 1, 8'h80,  1, 1});
        vecs.push_back('{0, 8'h00, 1, 0, 8'd0,  8'h7F,  8'h80, 1, 1, 8'h80,  0, 0});
        vecs.push_back('{1, 8'd50, 1, 0, 8'd20, 8'd100, 8'h9C, 0, 0, 8'd50,  0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'd50, 8'd100, 8'h9C, 0, 1, 8'd100, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 0, 8'd1,  8'd100, 8'h9C, 1, 1, 8'd100, 1, 0});
        vecs.push_back('{0, 8'h00, 1, 1, 8'd0,  8'd100, 8'h9C, 1, 1, 8'd100, 0, 0});
        vecs.push_back('{0, 8'h00, 0, 0, 8'd0,  8'd100, 8'h9C, 0, 1, 8'd100, 0, 0});
        vecs.push_back('{0, 8'h00, 1, 1, 8'd120,8'd100, 8'h9C, 0, 1, 8'hEC,  0, 0});
        vecs.push_back('{0, 8'h00, 1, 1, 8'd100,8'd100, 8'h9C, 0, 1, 8'h9C,  0, 1});

        @(negedge clk);
        clr = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            ld = vecs[i].ld; ldv = vecs[i].ldv; iv = vecs[i].iv; as_ = vecs[i].as_;
            ival = vecs[i].val; maxl = vecs[i].mx; minl = vecs[i].mn; clrf = vecs[i].clrf;
            ordy = 1'b1;
            #1;
            chk($sformatf("vec%0d ready", i), irdy, vecs[i].exp_rdy);
            pushed = vecs[i].ld || (vecs[i].iv && vecs[i].exp_rdy);
            if (pushed) sb.push_back('{vecs[i].exp_tot, vecs[i].exp_om, vecs[i].exp_um});
            @(posedge clk);
            #1;
            if (pushed) begin
                chk($sformatf("vec%0d valid", i), ov, 1);
                if (sb.size() == 0) begin
                    chk($sformatf("vec%0d scoreboard", i), 0, 1);
                end else begin
                    r = sb.pop_front();
                    chk($sformatf("vec%0d total", i), tot, r.tot);
                    chk($sformatf("vec%0d over", i), om, r.om);
                    chk($sformatf("vec%0d under", i), um, r.um);
                end
            end else begin
                chk($sformatf("vec%0d idle valid", i), ov, 0);
            end
        end
        chk("scoreboard empty", sb.size(), 0);

        // Stall: total is -100 here. Drain first, then accept +3 with no downstream ready.
        @(negedge clk);
        ld = 0; iv = 0; clrf = 0; ordy = 1; maxl = 8'd100; minl = 8'h9C;
        @(negedge clk);
        iv = 1; as_ = 0; ival = 8'd3; ordy = 0;
        #1;
        chk("stall accept ready", irdy, 1);
        @(posedge clk);
        #1;
        chk("stall first total", tot, 8'h9F);
        chk("stall first valid", ov, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d ready", c), irdy, 0);
            chk($sformatf("stall%0d total", c), tot, 8'h9F);
            chk($sformatf("stall%0d valid", c), ov, 1);
        end
        iv = 0; ordy = 1;
        #1;
        chk("release ready", irdy, 1);
        @(posedge clk);
        #1;
        chk("release valid drops", ov, 0);
        chk("release total", tot, 8'h9F);

        // Clear during a stall. The load of 120 clips to 100, and the under flag is still set.
        @(negedge clk);
        ld = 1; ldv = 8'd120; ordy = 0;
        @(posedge clk);
        #1;
        chk("pre-clear total", tot, 8'd100);
        chk("pre-clear over", om, 1);
        chk("pre-clear valid", ov, 1);
        @(negedge clk);
        ld = 0; clr = 1;
        @(posedge clk);
        #1;
        chk("clear total", tot, 0);
        chk("clear valid", ov, 0);
        chk("clear over", om, 0);
        chk("clear under", um, 0);
        @(negedge clk);
        clr = 0;
        @(posedge clk);
        #1;
        chk("post-clear no pulse", ov, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
